// File: rtl/reg_ld_arb.sv
// Two-requester round-robin arbiter feeding one shared 16-bit load-enabled register.
// Define REQ_SYNC_EN to pass req0/req1 through two-flop synchronisers before the FSM.
module reg_ld_arb (
    input  logic        clk,
    input  logic        resetl,
    input  logic        req0,
    input  logic [0:15] dat0,
    output logic        ack0,
    input  logic        req1,
    input  logic [0:15] dat1,
    output logic        ack1,
    output logic        ld,
    output logic [0:15] d,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        lp_q, lp_d;
    logic        owner_q, owner_d;
    logic [0:15] d_q, d_d;
    logic        ld_q, ld_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        busy_q, busy_d;

    logic [1:0]  eff_req_s;
    logic        grant_vld_s;
    logic        grant_s;

`ifdef REQ_SYNC_EN
    logic [1:0]  sync1_q, sync1_d;
    logic [1:0]  sync2_q, sync2_d;
    logic        stale_q, stale_d;
    logic        mask_s;

    // Synchroniser stages plus the flag marking the IDLE cycle right after ACK
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            stale_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            stale_q <= stale_d;
        end
    end

    // The owner's synchronised request lags its ack, so mask it until it has drained
    always_comb begin
        sync1_d      = {req1, req0};
        sync2_d      = sync1_q;
        stale_d      = (state_q == ST_ACK);
        mask_s       = (state_q == ST_ACK) || stale_q;
        eff_req_s[0] = sync2_q[0] & ~(mask_s & ~owner_q);
        eff_req_s[1] = sync2_q[1] & ~(mask_s & owner_q);
    end
`else
    // Requests drive the arbiter directly
    always_comb begin
        eff_req_s = {req1, req0};
    end
`endif

    // Round-robin pick: on a tie the requester that was not served last wins
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = 1'b0;
        case (eff_req_s)
            2'b01: begin
                grant_vld_s = 1'b1;
                grant_s     = 1'b0;
            end
            2'b10: begin
                grant_vld_s = 1'b1;
                grant_s     = 1'b1;
            end
            2'b11: begin
                grant_vld_s = 1'b1;
                grant_s     = ~lp_q;
            end
            default: begin
                grant_vld_s = 1'b0;
                grant_s     = 1'b0;
            end
        endcase
    end

    // Next state and next-cycle outputs; outputs are decoded from the state being entered
    always_comb begin
        state_d = state_q;
        lp_d    = lp_q;
        owner_d = owner_q;
        d_d     = d_q;
        ld_d    = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    state_d = ST_LOAD;
                    owner_d = grant_s;
                    d_d     = grant_s ? dat1 : dat0;
                    ld_d    = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_ACK;
                ack0_d  = ~owner_q;
                ack1_d  = owner_q;
                busy_d  = 1'b1;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                lp_d    = owner_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; lp resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= ST_IDLE;
            lp_q    <= 1'b1;
            owner_q <= 1'b0;
            d_q     <= 16'h0000;
            ld_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lp_q    <= lp_d;
            owner_q <= owner_d;
            d_q     <= d_d;
            ld_q    <= ld_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign ld    = ld_q;
    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign d     = d_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_reg_ld_arb.sv
// Scoreboard bench for reg_ld_arb: stimulus queues expected ld/ack events,
// a negedge monitor pops and compares each one the DUT presents.
module tb_reg_ld_arb;

`ifdef REQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        resetl;
    logic        req0, req1;
    logic [0:15] dat0, dat1;
    logic        ack0, ack1, ld, owner, busy;
    logic [0:15] d;

    typedef struct {
        bit          is_ack;
        bit          who;
        logic [0:15] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    reg_ld_arb dut (
        .clk    (clk),
        .resetl (resetl),
        .req0   (req0),
        .dat0   (dat0),
        .ack0   (ack0),
        .req1   (req1),
        .dat1   (dat1),
        .ack1   (ack1),
        .ld     (ld),
        .d      (d),
        .owner  (owner),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every ld or ack must match the head of the expected queue
    always @(negedge clk) begin
        exp_t e;
        bit   act_ack;
        bit   act_who;
        if (resetl && (ld || ack0 || ack1)) begin
            checks++;
            if ((ld && (ack0 || ack1)) || (ack0 && ack1)) begin
                failures++;
                $display("FAIL exclusive: ld=%0d ack0=%0d ack1=%0d, want at most one high", ld, ack0, ack1);
            end
            act_ack = ack0 || ack1;
            act_who = act_ack ? ack1 : owner;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected: ld=%0d ack0=%0d ack1=%0d d=%h at cyc %0d, want no activity", ld, ack0, ack1, d, cyc);
            end else begin
                e = exp_q.pop_front();
                if (act_ack !== e.is_ack || act_who !== e.who || owner !== e.who ||
                    d !== e.data || busy !== 1'b1 || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL event: got ack=%0d who=%0d owner=%0d d=%h busy=%0d cyc=%0d, want ack=%0d who=%0d d=%h busy=1 cyc=%0d",
                             act_ack, act_who, owner, d, busy, cyc, e.is_ack, e.who, e.data, e.cyc);
                end
            end
        end
    end

    task automatic push_xfer(input bit who, input logic [0:15] data, input int ld_cyc, input bit with_ack);
        exp_t e;
        e.is_ack = 1'b0; e.who = who; e.data = data; e.cyc = ld_cyc;
        exp_q.push_back(e);
        if (with_ack) begin
            e.is_ack = 1'b1; e.cyc = ld_cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_ack(input bit who, input string name);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = who ? ack1 : ack0;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: ack%0d not seen within 40 cycles, want ack", name, who);
        end
    endtask

    task automatic wait_ld(input string name);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = ld;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: ld not seen within 40 cycles, want ld", name);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (ld !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0 ||
            owner !== 1'b0 || d !== 16'h0000) begin
            failures++;
            $display("FAIL %s: ld=%0d ack0=%0d ack1=%0d busy=%0d owner=%0d d=%h, want all 0",
                     name, ld, ack0, ack1, busy, owner, d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetl = 1'b0;
        #1;
        check_zero("reset_mid");
        @(negedge clk);
        resetl = 1'b1;
    endtask

    initial begin
        resetl = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        dat0 = 16'h0000; dat1 = 16'h0000;
        #2 resetl = 1'b0;
        #1 check_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        resetl = 1'b1;

        // Single request from requester 0
        dat0 = 16'hA5C3;
        req0 = 1'b1;
        push_xfer(1'b0, 16'hA5C3, cyc + LAT, 1'b1);
        wait_ack(1'b0, "t1_ack0");
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ld !== 1'b0 || ack0 !== 1'b0) begin
            failures++;
            $display("FAIL t1_idle: busy=%0d ld=%0d ack0=%0d, want 0 0 0", busy, ld, ack0);
        end
        idle(6);

        // Simultaneous held requests alternate, requester 0 first after reset
        do_reset();
        dat0 = 16'h1111;
        dat1 = 16'h2222;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int k = 0; k < 4; k++)
            push_xfer(k[0], k[0] ? 16'h2222 : 16'h1111, cyc + LAT + 3 * k, 1'b1);
        wait_ack(1'b0, "t2_ack0_a");
        wait_ack(1'b1, "t2_ack1_a");
        wait_ack(1'b0, "t2_ack0_b");
        req0 = 1'b0;
        wait_ack(1'b1, "t2_ack1_b");
        req1 = 1'b0;
        idle(6);

        // One-cycle pulse on req1 still completes exactly once
        dat1 = 16'h00FF;
        req1 = 1'b1;
        push_xfer(1'b1, 16'h00FF, cyc + LAT, 1'b1);
        @(negedge clk);
        req1 = 1'b0;
        wait_ack(1'b1, "t3_ack1");
        idle(6);

        // Reset during LOAD aborts the transfer without an ack
        dat0 = 16'h3C3C;
        req0 = 1'b1;
        push_xfer(1'b0, 16'h3C3C, cyc + LAT, 1'b0);
        wait_ld("t4_ld");
        #1 resetl = 1'b0;
        #1 check_zero("t4_reset_in_load");
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetl = 1'b1;
        dat0 = 16'h4444;
        dat1 = 16'h5555;
        req0 = 1'b1;
        req1 = 1'b1;
        push_xfer(1'b0, 16'h4444, cyc + LAT, 1'b1);
        push_xfer(1'b1, 16'h5555, cyc + LAT + 3, 1'b1);
        wait_ack(1'b0, "t4_ack0");
        req0 = 1'b0;
        wait_ack(1'b1, "t4_ack1");
        req1 = 1'b0;
        idle(6);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected events outstanding, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_ld_arb.md
REG_LD_ARB -- requirements
Module: reg_ld_arb

Interface
REQ-001 The block SHALL expose the following ports (name, direction, width, meaning):
- clk  in  1  single system clock; all state changes on its rising edge.
- resetl  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 write request; held high until ack0.
- dat0  in  16 [0:15]  requester 0 write data; stable while req0 is high.
- ack0  out  1  one-cycle completion strobe to requester 0.
- req1  in  1  requester 1 write request; same rules as req0.
- dat1  in  16 [0:15]  requester 1 write data.
- ack1  out  1  one-cycle completion strobe to requester 1.
- ld  out  1  load strobe to the shared 16-bit load-enabled register.
- d  out  16 [0:15]  data to the shared register.
- owner  out  1  index of the requester currently or last served.
- busy  out  1  high in every state except IDLE.
REQ-002 The block SHALL have no parameters; the width is fixed at 16 bits, indexed [0:15].

Function
REQ-003 The block SHALL implement a three-state FSM with states IDLE, LOAD and ACK.
REQ-004 In IDLE with no effective request, the FSM SHALL remain in IDLE with ld, ack0 and ack1 low.
REQ-005 In IDLE with at least one effective request, the FSM SHALL select a winner, register the winner's dat into d, set owner to the winner and enter LOAD on the next edge.
REQ-006 Arbitration SHALL be round-robin using a last-served pointer lp.
- Single request: that requester wins.
- Both requesting: the requester not equal to lp wins.
REQ-007 In LOAD, ld SHALL be high for exactly one cycle, d SHALL hold the latched value, and the FSM SHALL enter ACK.
REQ-008 In ACK, ack[owner] SHALL be high for exactly one cycle, lp SHALL be updated to owner, and the FSM SHALL return to IDLE.
REQ-009 All outputs SHALL be registered.
- Latency from the edge sampling req to ld high is 1 cycle; to ack high is 2 cycles.
- Throughput is at most one transfer per 3 cycles.
REQ-010 d SHALL hold its value outside LOAD and change only on an IDLE-to-LOAD transition.
REQ-011 ack0 and ack1 SHALL never be high in the same cycle, and ld and any ack SHALL never be high in the same cycle.
REQ-012 If a winner drops req after being latched, the transfer SHALL still complete, with ld and ack issued as normal.
REQ-013 A requester holding req high through its ack cycle SHALL be treated as a new request with new data in the following IDLE cycle.
REQ-014 Under continuous requests from both sides, grants SHALL alternate 0,1,0,1..., so no requester waits more than one transfer.

Reset
REQ-015 Assertion of resetl low SHALL, without waiting for a clock edge, force:
- the state to IDLE;
- ld, ack0, ack1, busy and owner to 0;
- d to 16'h0000;
- lp to 1, so requester 0 wins the first tie.
REQ-016 A reset asserted in LOAD or ACK SHALL abort the transfer with no ack issued; the requester must re-request.
REQ-017 Release of resetl SHALL be synchronous to clk; the first request can be sampled on the first edge after release.

Configuration
REQ-018 Macro REQ_SYNC_EN SHALL control input synchronisation.
- Defined: req0 and req1 each pass through a two-flop synchroniser (reset to 0) before the FSM, and the effective request is the synchronised value. Latency from req to ld becomes 3 cycles and to ack 4 cycles.
- Defined: the FSM SHALL ignore the synchronised request of the owner during ACK and the following IDLE cycle, preventing a stale re-grant.
- Undefined: req0 and req1 feed the FSM directly, with the latencies of REQ-009.
- dat0 and dat1 are never synchronised in either configuration.

Verification
REQ-019 The bench SHALL cover at least these directed scenarios (macro undefined unless stated):
- After reset, req0=1 with dat0=16'hA5C3 -> ld high at cycle 1 with d=16'hA5C3, ack0 high at cycle 2, owner=0, busy high for cycles 1-2.
- req0 and req1 rise together after reset, dat0=16'h1111, dat1=16'h2222, both held -> first ld with d=16'h1111 and ack0, next ld with d=16'h2222 and ack1, then alternating.
- req1 pulsed for one cycle with dat1=16'h00FF -> transfer completes, d=16'h00FF, ack1 high exactly once, no second transfer.
- resetl asserted in LOAD -> ld, ack0, ack1 and d go to 0 immediately, state IDLE, no ack observed; after release, the next tie is won by requester 0.
- With REQ_SYNC_EN defined, req0=1 with dat0=16'hBEEF -> ld at cycle 3, ack0 at cycle 4, and no duplicate transfer after req0 falls on ack0.
